// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock divider controller.
// Holds the controller state encoding and half-period clamp.
package clk_div_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } ctrl_state_e;

  localparam int CLK_DIV_WIDTH_DEF = 27;
  localparam int CLK_DIV_HALF_DEF  = 50_000_000;
  localparam int CLK_DIV_CLAMP_W   = 64;

  // A zero half-period cannot be counted, so it means divide-by-2.
  function automatic logic [CLK_DIV_CLAMP_W-1:0] clamp_half(
    input logic [CLK_DIV_CLAMP_W-1:0] v
  );
    return (v == '0) ? CLK_DIV_CLAMP_W'(1) : v;
  endfunction

endpackage

// File: rtl/div_counter.sv
// Half-period counter with output toggle and toggle tick.
// clear restarts the count without disturbing clock_out.
module div_counter
  import clk_div_pkg::*;
#(
  parameter int WIDTH = CLK_DIV_WIDTH_DEF
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] half,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             clock_out,
  output logic             tick
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = (count_q == half - WIDTH'(1));

  always_comb begin
    count_d = count_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (wrap) begin
        count_d = '0;
        clk_d   = ~clk_q;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset) begin
      count_q <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign count     = count_q;
  assign clock_out = clk_q;
  assign tick      = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider with handshaked half-period reconfiguration.
// CLK_DIV_CTRL_IMMEDIATE_EN: apply updates at once instead of at a boundary.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH        = CLK_DIV_WIDTH_DEF,
  parameter int DEFAULT_HALF = CLK_DIV_HALF_DEF
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clock_out,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             pending
);

  localparam logic [WIDTH-1:0] HALF_RST = WIDTH'(DEFAULT_HALF);

  ctrl_state_e      state_q;
  logic [WIDTH-1:0] half_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;
  logic             in_pend;
  logic             xfer;
  logic             wrap;
  logic             apply;
  logic             clear;

  assign in_pend   = (state_q == PENDING);
  assign cfg_ready = reset && !in_pend;
  assign pending   = reset && in_pend;
  assign xfer      = cfg_valid && cfg_ready;
  assign wrap      = enable && (count == half_q - WIDTH'(1));
  assign shadow_d  =
    WIDTH'(clamp_half(CLK_DIV_CLAMP_W'(cfg_half)));

`ifdef CLK_DIV_CTRL_IMMEDIATE_EN
  assign apply = in_pend;
  assign clear = in_pend;
`else
  // Swap only on a wrap, or while frozen, so no phase is shortened.
  assign apply = in_pend && (wrap || !enable);
  assign clear = in_pend && !enable && (count >= shadow_q);
`endif

  always_ff @(posedge clock_in) begin
    if (!reset) begin
      state_q  <= IDLE;
      half_q   <= HALF_RST;
      shadow_q <= HALF_RST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            shadow_q <= shadow_d;
            state_q  <= PENDING;
          end
        end
        PENDING: begin
          if (apply) begin
            half_q  <= shadow_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  div_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clock_in  (clock_in),
    .reset     (reset),
    .enable    (enable),
    .half      (half_q),
    .clear     (clear),
    .count     (count),
    .clock_out (clock_out),
    .tick      (tick)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with WIDTH=8, DEFAULT_HALF=4.
// Covers both builds via CLK_DIV_CTRL_IMMEDIATE_EN.
module tb_clk_div_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         cv = 1'b0;
  logic [W-1:0] ch = '0;
  logic         rdy;
  logic         cko;
  logic         tck;
  logic [W-1:0] cnt;
  logic         pnd;

  int checks = 0;
  int failures = 0;

  logic [7:0] ecnt [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  logic [7:0] eclk [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  logic [7:0] etck [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  clk_div_ctrl #(
    .WIDTH(W),
    .DEFAULT_HALF(4)
  ) dut (
    .clock_in  (clk),
    .reset     (rst_n),
    .enable    (en),
    .cfg_valid (cv),
    .cfg_half  (ch),
    .cfg_ready (rdy),
    .clock_out (cko),
    .tick      (tck),
    .count     (cnt),
    .pending   (pnd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] c,
                         input logic [7:0] k, input logic [7:0] t);
    chk({tag, "_cnt"}, cnt, c);
    chk({tag, "_clk"}, 8'(cko), k);
    chk({tag, "_tick"}, 8'(tck), t);
  endtask

  initial begin
    step();
    chk_out("rst", 0, 0, 0);
    chk("rst_ready", 8'(rdy), 0);
    chk("rst_pend", 8'(pnd), 0);

    rst_n = 1'b1;
    en = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      chk_out($sformatf("base%0d", e), ecnt[e], eclk[e], etck[e]);
    end
    chk("base_ready", 8'(rdy), 1);

`ifndef CLK_DIV_CTRL_IMMEDIATE_EN
    step();
    cv = 1'b1;
    ch = 8'd2;
    step();
    chk("h2_pend", 8'(pnd), 1);
    chk("h2_ready", 8'(rdy), 0);
    chk("h2_cnt", cnt, 2);
    ch = 8'd7;
    step();
    cv = 1'b0;
    chk("h2_pend2", 8'(pnd), 1);
    chk("h2_cnt2", cnt, 3);
    step();
    chk_out("h2_wrap", 0, 1, 1);
    chk("h2_pend3", 8'(pnd), 0);
    chk("h2_ready3", 8'(rdy), 1);
    step();
    chk_out("h2_e13", 1, 1, 0);
    step();
    chk_out("h2_e14", 0, 0, 1);
    step();
    step();
    chk_out("h2_e16", 0, 1, 1);

    cv = 1'b1;
    ch = 8'd0;
    step();
    chk("h0_pend", 8'(pnd), 1);
    cv = 1'b0;
    step();
    chk_out("h0_apply", 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out($sformatf("h0_run%0d", i), 0,
              (i % 2 == 0) ? 8'd1 : 8'd0, 1);
    end

    cv = 1'b1;
    ch = 8'd4;
    step();
    chk_out("h4_xfer", 0, 1, 1);
    cv = 1'b0;
    step();
    chk_out("h4_apply", 0, 0, 1);
    chk("h4_pend", 8'(pnd), 0);
    step();
    chk("h4_cnt", cnt, 1);
    cv = 1'b1;
    ch = 8'd2;
    step();
    chk("fz_cnt", cnt, 2);
    chk("fz_pend", 8'(pnd), 1);
    cv = 1'b0;
    en = 1'b0;
    step();
    chk_out("fz_apply", 0, 0, 0);
    chk("fz_pend2", 8'(pnd), 0);
    en = 1'b1;
    step();
    chk("fz_run", cnt, 1);
    en = 1'b0;
    step();
    chk_out("fz_hold", 1, 0, 0);
    en = 1'b1;
    step();
    chk_out("fz_wrap", 0, 1, 1);

    cv = 1'b1;
    ch = 8'd6;
    step();
    chk("rp_pend", 8'(pnd), 1);
    cv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rp_pend_lo", 8'(pnd), 0);
    chk("rp_ready_lo", 8'(rdy), 0);
    step();
    chk_out("rp_rst", 0, 0, 0);
    rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      chk_out($sformatf("rp%0d", e), ecnt[e], eclk[e], etck[e]);
    end
    chk("rp_pend2", 8'(pnd), 0);
`else
    step();
    step();
    cv = 1'b1;
    ch = 8'd6;
    step();
    cv = 1'b0;
    chk("im_pend", 8'(pnd), 1);
    chk("im_cnt", cnt, 3);
    step();
    chk_out("im_apply", 0, 0, 0);
    chk("im_pend2", 8'(pnd), 0);
    for (int i = 1; i < 6; i++) begin
      step();
      chk_out($sformatf("im_run%0d", i), 8'(i), 0, 0);
    end
    step();
    chk_out("im_wrap", 0, 1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
